// File: rtl/sim_spi_ram_pkg.sv
// Shared opcodes, FSM state encoding and bit-count constants for the SPI RAM bank model.
package sim_spi_ram_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(23);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
`ifdef SIM_SPI_RAM_FAST_READ_EN
    , ST_DUMMY
`endif
  } state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_FAST_READ
  } op_t;

endpackage

// File: rtl/spi_clk_edge.sv
// Registers the core-synchronous spi_clk and flags its rising and falling edges.
module spi_clk_edge (
  input  logic clk,
  input  logic rstn,
  input  logic spi_clk,
  output logic rise,
  output logic fall
);

  logic spi_clk_q;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) spi_clk_q <= 1'b0;
    else       spi_clk_q <= spi_clk;
  end

  assign rise = spi_clk & ~spi_clk_q;
  assign fall = ~spi_clk & spi_clk_q;

endmodule

// File: rtl/sim_spi_ram_multi.sv
// Clock-synchronous model of NUM_CS SPI RAMs on a shared bus (READ/WRITE).
// Define SIM_SPI_RAM_FAST_READ_EN to accept FAST READ (0x0B) with 8 dummy clocks.
module sim_spi_ram_multi
  import sim_spi_ram_pkg::*;
#(
  parameter int    NUM_CS    = 2,
  parameter int    ADDR_BITS = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic [NUM_CS-1:0] spi_select,
  output logic              spi_miso
);

  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic rise, fall;

  spi_clk_edge u_edge (
    .clk     (clk),
    .rstn    (rstn),
    .spi_clk (spi_clk),
    .rise    (rise),
    .fall    (fall)
  );

  state_t               state;
  op_t                  op_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic [ADDR_BITS-2:0] shift_in;
  logic [ADDR_BITS-1:0] addr;
  logic [SEL_W-1:0]     sel_q;
  logic [7:0]           data_sr;

  logic                 any_sel;
  logic [SEL_W-1:0]     active_idx;
  logic [ADDR_BITS-1:0] shift_full;
  logic [7:0]           wr_byte;
  logic                 wr_en;
  logic [7:0]           rd_byte [NUM_CS];
  logic [7:0]           rd_data;

  assign any_sel    = ~&spi_select;
  // Only the last ADDR_BITS serial bits matter: upper address bits fall off the end.
  assign shift_full = {shift_in, spi_mosi};
  assign wr_byte    = {data_sr[6:0], spi_mosi};
  assign wr_en      = any_sel && (state == ST_WRITE) && rise && (bit_cnt == BYTE_LAST);
  assign rd_data    = rd_byte[sel_q];

  // NOTE: a default before the loop keeps this purely combinational (no latch).
  always_comb begin
    active_idx = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (!spi_select[i]) active_idx = SEL_W'(i);
    end
  end

  for (genvar g = 0; g < NUM_CS; g++) begin : g_dev
    logic [7:0] mem [DEPTH];

    // NOTE: the array is deliberately left out of reset; RAM contents survive rstn.
    always_ff @(posedge clk) begin
      if (wr_en && (sel_q == SEL_W'(g))) mem[addr] <= wr_byte;
    end

    assign rd_byte[g] = mem[addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      op_q     <= OP_READ;
      bit_cnt  <= '0;
      shift_in <= '0;
      addr     <= '0;
      sel_q    <= '0;
      data_sr  <= '0;
      spi_miso <= 1'b0;
    end else if (!any_sel) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      spi_miso <= 1'b0;
    end else begin
      if (state != ST_READ) spi_miso <= 1'b0;
      case (state)
        ST_IDLE: if (rise) begin
          sel_q    <= active_idx;
          shift_in <= shift_full[ADDR_BITS-2:0];
          bit_cnt  <= CNT_W'(1);
          state    <= ST_CMD;
        end
        ST_CMD: if (rise) begin
          shift_in <= shift_full[ADDR_BITS-2:0];
          if (bit_cnt == BYTE_LAST) begin
            bit_cnt <= '0;
            state   <= ST_ADDR;
            case (shift_full[7:0])
              CMD_READ:      op_q  <= OP_READ;
              CMD_WRITE:     op_q  <= OP_WRITE;
`ifdef SIM_SPI_RAM_FAST_READ_EN
              CMD_FAST_READ: op_q  <= OP_FAST_READ;
`endif
              default:       state <= ST_IGNORE;
            endcase
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_ADDR: if (rise) begin
          shift_in <= shift_full[ADDR_BITS-2:0];
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt <= '0;
            addr    <= shift_full;
            if (op_q == OP_WRITE) state <= ST_WRITE;
`ifdef SIM_SPI_RAM_FAST_READ_EN
            else if (op_q == OP_FAST_READ) state <= ST_DUMMY;
`endif
            else state <= ST_READ;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef SIM_SPI_RAM_FAST_READ_EN
        ST_DUMMY: if (rise) begin
          if (bit_cnt == BYTE_LAST) begin
            bit_cnt <= '0;
            state   <= ST_READ;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`endif
        // Each byte is fetched at its first fall, so a just-committed write is visible.
        ST_READ: if (fall) begin
          if (bit_cnt == '0) begin
            spi_miso <= rd_data[7];
            data_sr  <= {rd_data[6:0], 1'b0};
          end else begin
            spi_miso <= data_sr[7];
            data_sr  <= {data_sr[6:0], 1'b0};
          end
          if (bit_cnt == BYTE_LAST) begin
            bit_cnt <= '0;
            addr    <= addr + ADDR_BITS'(1);
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_WRITE: if (rise) begin
          data_sr <= wr_byte;
          if (bit_cnt == BYTE_LAST) begin
            bit_cnt <= '0;
            addr    <= addr + ADDR_BITS'(1);
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_spi_ram_multi.sv
// Randomised scoreboard bench for sim_spi_ram_multi: a byte-array model predicts read data.
module tb_sim_spi_ram_multi;

  localparam int NUM_CS = 2;
  localparam int AB     = 16;
  localparam int DEPTH  = 1 << AB;
  localparam logic [23:0] WIN_BASE = 24'h00FFF4;
  localparam int          WIN_LEN  = 24;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              spi_clk = 1'b0;
  logic              spi_mosi = 1'b0;
  logic [NUM_CS-1:0] spi_select = '1;
  logic              spi_miso;

  always #5 clk = ~clk;

  sim_spi_ram_multi #(
    .NUM_CS    (NUM_CS),
    .ADDR_BITS (AB),
    .INIT_FILE ("")
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_select (spi_select),
    .spi_miso   (spi_miso)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] mdl [NUM_CS][DEPTH];
  logic [7:0] tx_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];
  event       got_rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [NUM_CS-1:0] s);
    for (int i = 0; i < NUM_CS; i++) if (!s[i]) return i;
    return 0;
  endfunction

  function automatic int midx(input logic [23:0] a, input int off);
    return (int'(a) + off) % DEPTH;
  endfunction

  // One SPI mode-0 bit: present MOSI, sample MISO just before the rise.
  task automatic bit_x(input logic b, output logic r);
    spi_mosi = b;
    tick($urandom_range(1, 2));
    r = spi_miso;
    spi_clk = 1'b1;
    tick($urandom_range(1, 2));
    spi_clk = 1'b0;
  endtask

  task automatic spi_run(input logic [NUM_CS-1:0] sel, input logic [NUM_CS-1:0] sel2,
                         input int bit_limit, input int from);
    logic [7:0] r;
    logic       rb;
    int         nb;
    nb = 0;
    spi_select = sel;
    tick(1);
    foreach (tx_q[i]) begin
      if (i == 1) spi_select = sel2;
      r = 8'h00;
      for (int b = 7; b >= 0; b--) begin
        if (bit_limit >= 0 && nb >= bit_limit) break;
        bit_x(tx_q[i][b], rb);
        r[b] = rb;
        nb++;
      end
      if (i >= from && (bit_limit < 0 || nb <= bit_limit) && (bit_limit < 0 || (i + 1) * 8 <= bit_limit))
        act_q.push_back(r);
    end
    -> got_rx;
    tick(1);
    spi_select = '1;
    tick(1);
    check("miso_after_deselect", spi_miso, 0);
    tick(1);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [23:0] a);
    tx_q.delete();
    tx_q.push_back(op);
    tx_q.push_back(a[23:16]);
    tx_q.push_back(a[15:8]);
    tx_q.push_back(a[7:0]);
  endtask

  task automatic wr(input logic [NUM_CS-1:0] sel, input logic [NUM_CS-1:0] sel2, input logic [23:0] a);
    int dev;
    dev = lowest(sel);
    hdr(8'h02, a);
    foreach (wr_q[i]) begin
      tx_q.push_back(wr_q[i]);
      mdl[dev][midx(a, i)] = wr_q[i];
    end
    spi_run(sel, sel2, -1, 1 << 20);
  endtask

  task automatic rd(input logic [NUM_CS-1:0] sel, input logic [NUM_CS-1:0] sel2,
                    input logic [23:0] a, input int n, input bit fast);
    int dev;
    dev = lowest(sel);
    hdr(fast ? 8'h0B : 8'h03, a);
    if (fast) tx_q.push_back(8'($urandom));
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(8'($urandom));
      exp_q.push_back(mdl[dev][midx(a, i)]);
    end
    spi_run(sel, sel2, -1, fast ? 5 : 4);
  endtask

  task automatic fill_rand(input int n);
    wr_q.delete();
    for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom));
  endtask

  function automatic logic [NUM_CS-1:0] dev_sel(input int dev);
    logic [NUM_CS-1:0] s;
    s = '1;
    s[dev] = 1'b0;
    return s;
  endfunction

  // Scoreboard monitor: compares every captured read byte with the predicted one.
  initial begin
    logic [7:0] a;
    logic [7:0] e;
    forever begin
      @(got_rx);
      while (act_q.size() != 0) begin
        a = act_q.pop_front();
        check("sb_expected_pending", exp_q.size() != 0, 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check("sb_read_byte", a, e);
      end
    end
  end

  initial begin
    logic       rb;
    logic [7:0] b;
    int         guard;

    tick(3);
    check("reset_miso", spi_miso, 0);
    rstn = 1'b1;
    tick(2);

    for (int d = 0; d < NUM_CS; d++) begin
      fill_rand(WIN_LEN); wr(dev_sel(d), dev_sel(d), WIN_BASE);
      fill_rand(4);       wr(dev_sel(d), dev_sel(d), 24'h001234);
      fill_rand(4);       wr(dev_sel(d), dev_sel(d), 24'h000100);
      fill_rand(4);       wr(dev_sel(d), dev_sel(d), 24'h000200);
      fill_rand(4);       wr(dev_sel(d), dev_sel(d), 24'h000010);
    end
    rd(2'b10, 2'b10, WIN_BASE, WIN_LEN, 1'b0);

    wr_q = '{8'hA5, 8'h5A};
    wr(2'b01, 2'b01, 24'h001234);
    rd(2'b01, 2'b01, 24'h001234, 2, 1'b0);
    rd(2'b10, 2'b10, 24'h001234, 2, 1'b0);

    wr_q = '{8'h11, 8'h22};
    wr(2'b10, 2'b10, 24'h00FFFF);
    rd(2'b10, 2'b10, 24'h000000, 1, 1'b0);
    rd(2'b10, 2'b10, 24'hFF0000, 1, 1'b0);
    rd(2'b10, 2'b10, 24'h00FFFE, 3, 1'b0);

    wr_q = '{8'h3C};
    wr(2'b10, 2'b10, 24'h000100);
    hdr(8'h02, 24'h000100);
    tx_q.push_back(8'hCC);
    spi_run(2'b10, 2'b10, 37, 1 << 20);
    rd(2'b10, 2'b10, 24'h000100, 1, 1'b0);

    hdr(8'h9F, 24'(WIN_BASE));
    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    spi_run(2'b10, 2'b10, -1, 0);
    rd(2'b10, 2'b10, WIN_BASE, WIN_LEN, 1'b0);

`ifdef SIM_SPI_RAM_FAST_READ_EN
    rd(2'b10, 2'b10, 24'h000010, 2, 1'b1);
`else
    hdr(8'h0B, 24'h000010);
    tx_q.push_back(8'($urandom));
    tx_q.push_back(8'($urandom));
    exp_q.push_back(8'h00);
    spi_run(2'b10, 2'b10, -1, 5);
`endif

    fill_rand(2);
    wr(2'b00, 2'b00, 24'h000200);
    rd(2'b01, 2'b01, 24'h000200, 4, 1'b0);
    rd(2'b10, 2'b10, 24'h000200, 4, 1'b0);

    fill_rand(3);
    wr(2'b10, 2'b01, 24'h000100);
    rd(2'b01, 2'b01, 24'h000100, 4, 1'b0);
    rd(2'b10, 2'b10, 24'h000100, 4, 1'b0);

    // Reset in the middle of a READ of 0xFF: MISO must drop to 0 at once.
    wr_q = '{8'hFF};
    wr(2'b10, 2'b10, 24'h000003);
    hdr(8'h03, 24'h000003);
    spi_select = 2'b10;
    tick(1);
    foreach (tx_q[i]) for (int k = 7; k >= 0; k--) bit_x(tx_q[i][k], rb);
    for (int k = 0; k < 3; k++) begin
      bit_x(1'b0, rb);
      check("pre_reset_bit", rb, mdl[0][3][7 - k]);
    end
    tick(1);
    check("pre_reset_miso", spi_miso, mdl[0][3][4]);
    rstn = 1'b0;
    #1;
    check("reset_async_miso", spi_miso, 0);
    tick(1);
    check("reset_held_miso", spi_miso, 0);
    spi_select = '1;
    tick(1);
    rstn = 1'b1;
    tick(2);
    rd(2'b10, 2'b10, 24'h000000, 4, 1'b0);

    for (int it = 0; it < 30; it++) begin
      int               dev;
      int               off;
      int               len;
      logic [NUM_CS-1:0] sel;
      logic [NUM_CS-1:0] sel2;
      logic [23:0]       a;
      dev  = $urandom_range(0, NUM_CS - 1);
      sel  = ($urandom_range(0, 3) == 0) ? 2'b00 : dev_sel(dev);
      sel2 = ($urandom_range(0, 3) == 0) ? dev_sel($urandom_range(0, NUM_CS - 1)) : sel;
      off  = $urandom_range(0, WIN_LEN - 1);
      len  = $urandom_range(1, (WIN_LEN - off < 4) ? WIN_LEN - off : 4);
      a    = {8'($urandom), 16'(midx(WIN_BASE, off))};
      if ($urandom_range(0, 1) == 0) begin
        fill_rand(len);
        wr(sel, sel2, a);
      end else begin
        rd(sel, sel2, a, len, 1'b0);
      end
    end
    rd(2'b10, 2'b10, WIN_BASE, WIN_LEN, 1'b0);
    rd(2'b01, 2'b01, WIN_BASE, WIN_LEN, 1'b0);

    guard = 0;
    while (act_q.size() != 0 && guard < 100) begin
      tick(1);
      guard++;
    end
    check("sb_drained_actual", act_q.size(), 0);
    check("sb_drained_expected", exp_q.size(), 0);
    b = 8'h00;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
